d_compressor: RTL and testbench

- Static dynamic-range compressor for a signed 8-bit sample stream. Every clock it takes one two's-complement sample, applies a hard-knee threshold/ratio curve to the sample magnitude, and outputs the compressed sample with its sign restored.
- Sits in the audio/DSP filter chain between sample source and downstream filters. There is no handshake: one sample is accepted per clock.

---
 rtl/d_compressor.sv | 68 ++++++
 tb/tb_d_compressor.sv | 139 +++++++++++++
 2 files changed

// File: rtl/d_compressor.sv
// Purpose: hard-knee static compressor for a signed sample stream (threshold + 2^RATIO_SHIFT:1 above it).
// Latency: 2 register stages; a sample taken at edge k is on o_data after edge k+1.
// Backpressure: none; one sample is accepted and one produced every clock.
module d_compressor #(
    parameter int DW          = 8,
    parameter int THRESHOLD   = 64,
    parameter int RATIO_SHIFT = 2
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic [DW-1:0] i_data,
    output logic [DW-1:0] o_data
);

    // Knee and zero carried at magnitude width (one bit wider than the sample so -2^(DW-1) fits).
    localparam logic [DW:0] TH   = (DW+1)'(THRESHOLD);
    localparam logic [DW:0] ZERO = '0;

    // Out-of-range configuration stops elaboration.
    generate
        if ((DW < 2) || (THRESHOLD < 0) || (THRESHOLD > (2 ** (DW - 1)) - 1) ||
            (RATIO_SHIFT < 0) || (RATIO_SHIFT > 7)) begin : g_bad_cfg
            $error("d_compressor: illegal parameter set (DW/THRESHOLD/RATIO_SHIFT out of range)");
        end
    endgenerate

    logic          sign_d, sign_q;
    logic [DW:0]   mag_d,  mag_q;
    logic [DW:0]   ext;
    logic [DW:0]   ym;
    logic [DW-1:0] out_d,  out_q;

    // Stage 1: split the sample into sign and unsigned magnitude.
    always_comb begin
        ext    = {i_data[DW-1], i_data};
        sign_d = i_data[DW-1];
        mag_d  = ext;
        if (i_data[DW-1]) begin
            mag_d = ZERO - ext;
        end
    end

    // Stage 2: apply the knee curve to the magnitude (floored, so rounding is toward zero), then restore sign.
    always_comb begin
        ym = mag_q;
        if (mag_q > TH) begin
            ym = TH + ((mag_q - TH) >> RATIO_SHIFT);
        end
        // y_m never exceeds the input magnitude, so the truncation cannot wrap a positive result.
        out_d = DW'(sign_q ? (ZERO - ym) : ym);
    end

    // Pipeline registers; reset clears every stage so no in-flight sample survives it.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sign_q <= 1'b0;
            mag_q  <= '0;
            out_q  <= '0;
        end else begin
            sign_q <= sign_d;
            mag_q  <= mag_d;
            out_q  <= out_d;
        end
    end

    assign o_data = out_q;

endmodule

// File: tb/tb_d_compressor.sv
// Bench for d_compressor: directed knee/latency/reset cases plus a random regression,
// run against a default instance (4:1) and an identity instance (RATIO_SHIFT=0) in parallel.
// Expected values come from an arithmetic model of the transfer curve and constant tables.
module tb_d_compressor;

    localparam int TH = 64;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic [7:0] i_data;
    logic [7:0] o_data;
    logic [7:0] o_data_r0;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] prev_d = 8'h00;
    logic       prev_r = 1'b1;

    d_compressor #(.DW(8), .THRESHOLD(TH), .RATIO_SHIFT(2)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_data  (i_data),
        .o_data  (o_data)
    );

    d_compressor #(.DW(8), .THRESHOLD(TH), .RATIO_SHIFT(0)) dut_r0 (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_data  (i_data),
        .o_data  (o_data_r0)
    );

    always #5 i_clk = ~i_clk;

    // Transfer curve computed from the sample value with plain integer arithmetic.
    function automatic logic [7:0] ref_out(logic [7:0] x, int rs);
        int v, m, y, o;
        v = $signed(x);
        m = (v < 0) ? -v : v;
        y = (m <= TH) ? m : TH + ((m - TH) >> rs);
        o = (v < 0) ? -y : y;
        return o[7:0];
    endfunction

    task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    // Drive one sample for one edge, then check both instances against the model.
    // Output after an edge reflects the sample of the previous edge, or 0 if either edge was in reset.
    task automatic cycle(logic [7:0] d, logic r);
        logic [7:0] e2, e0;
        i_data  = d;
        i_reset = r;
        @(posedge i_clk);
        #1;
        e2 = (r || prev_r) ? 8'h00 : ref_out(prev_d, 2);
        e0 = (r || prev_r) ? 8'h00 : ref_out(prev_d, 0);
        chk("model_rs2", o_data, e2);
        chk("model_rs0", o_data_r0, e0);
        prev_d = d;
        prev_r = r;
    endtask

    logic [7:0] pt_in  [4] = '{8'd10, 8'd64, 8'hF6, 8'hC0};
    logic [7:0] kn_in  [7] = '{8'd65, 8'd68, 8'd100, 8'd127, 8'h81, 8'h80, 8'h9C};
    logic [7:0] kn_out [7] = '{8'd64, 8'd65, 8'd73,  8'h4F,  8'hB1, 8'hB0, 8'hB7};
    logic [7:0] prev_o;

    initial begin
        i_reset = 1'b1;
        i_data  = 8'h00;

        // Reset state
        cycle(8'h00, 1'b1);
        cycle(8'h00, 1'b1);
        chk("reset_state", o_data, 8'h00);
        chk("reset_state_r0", o_data_r0, 8'h00);

        // Pass-through region: output equals input one edge later
        for (int i = 0; i < 4; i++) begin
            cycle(pt_in[i], 1'b0);
            if (i > 0) chk("pass", o_data, pt_in[i-1]);
        end
        cycle(8'h00, 1'b0);
        chk("pass", o_data, pt_in[3]);

        // Above the knee, both signs, including -128
        for (int i = 0; i < 7; i++) begin
            cycle(kn_in[i], 1'b0);
            if (i > 0) begin
                chk("knee", o_data, kn_out[i-1]);
                chk("rs0_identity", o_data_r0, kn_in[i-1]);
            end
        end
        cycle(8'h00, 1'b0);
        chk("knee", o_data, kn_out[6]);
        chk("rs0_identity", o_data_r0, kn_in[6]);
        cycle(8'h00, 1'b0);
        chk("zero_in", o_data, 8'h00);

        // Ramp 0..127: one output per clock, monotonic non-decreasing
        prev_o = 8'h00;
        for (int v = 0; v < 128; v++) begin
            cycle(8'(v), 1'b0);
            if (v >= 2) chk("ramp_mono", {7'b0, (o_data >= prev_o)}, 8'h01);
            prev_o = o_data;
        end
        cycle(8'h00, 1'b0);
        chk("ramp_last", o_data, 8'h4F);

        // Reset mid-stream discards the in-flight sample
        cycle(8'd127, 1'b0);
        cycle(8'd127, 1'b0);
        chk("rst_pre", o_data, 8'd79);
        cycle(8'd127, 1'b1);
        chk("rst_edge", o_data, 8'h00);
        cycle(8'd127, 1'b0);
        chk("rst_after", o_data, 8'h00);
        cycle(8'd127, 1'b0);
        chk("rst_resume", o_data, 8'd79);

        // Random regression after a 2-clock reset, with occasional resets sprinkled in
        cycle(8'($urandom), 1'b1);
        cycle(8'($urandom), 1'b1);
        for (int i = 0; i < 10000; i++) begin
            cycle(8'($urandom), ($urandom_range(0, 199) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
